// File: rtl/indec_until_delim_1_1_8_8.sv
// Serial decimal decoder: UART 8N1 receiver feeding a digit parser that
// accumulates an 8-bit saturating value until the caller's delimiter byte.
module indec_until_delim_1_1_8_8 #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       inchan,
  input  logic [7:0] delimbyte,
  output logic [7:0] result,
  output logic       result_ready,
  output logic       overflow,
  output logic       empty
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    P_READY,
    P_ACCEPT
  } parse_state_t;

  // ---------------- receiver ----------------
  logic            sync1, sync2;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   clk_cnt, clk_cnt_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic [7:0]      shift, shift_next;
  logic            byte_valid, byte_valid_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
    end else begin
      sync1      <= inchan;
      sync2      <= sync1;
      rx_state   <= rx_next;
      clk_cnt    <= clk_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift      <= shift_next;
      byte_valid <= byte_valid_next;
    end
  end

  always_comb begin
    rx_next         = rx_state;
    clk_cnt_next    = clk_cnt;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift;
    byte_valid_next = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (!sync2) rx_next = RX_START;
      end
      RX_START: begin
        // Recheck at mid start bit so short glitches do not start a frame.
        if (clk_cnt == HALF_M1) begin
          clk_cnt_next = '0;
          rx_next      = sync2 ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_next = '0;
          shift_next   = {sync2, shift[7:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) rx_next = RX_STOP;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_next = '0;
          if (sync2) begin
            byte_valid_next = 1'b1;
            rx_next         = RX_IDLE;
          end else begin
            rx_next = RX_WAIT_HIGH;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (sync2) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // ---------------- parser ----------------
  parse_state_t p_state, p_next;
  logic [7:0]   acc, acc_next;
  logic [7:0]   delim, delim_next;
  logic         seen_digit, seen_next;
  logic [7:0]   result_next;
  logic         overflow_next, empty_next;
  logic         is_digit;
  logic [7:0]   digit;
  logic [11:0]  acc_x10;

  assign is_digit = (shift >= 8'h30) && (shift <= 8'h39);
  assign digit    = shift - 8'h30;
  assign acc_x10  = {4'b0, acc} * 12'd10 + {8'b0, digit[3:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_state    <= P_READY;
      acc        <= '0;
      delim      <= '0;
      seen_digit <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      empty      <= 1'b0;
    end else begin
      p_state    <= p_next;
      acc        <= acc_next;
      delim      <= delim_next;
      seen_digit <= seen_next;
      result     <= result_next;
      overflow   <= overflow_next;
      empty      <= empty_next;
    end
  end

  always_comb begin
    p_next        = p_state;
    acc_next      = acc;
    delim_next    = delim;
    seen_next     = seen_digit;
    result_next   = result;
    overflow_next = overflow;
    empty_next    = empty;
    if (start) begin
      // A new call always wins, even over a byte completing this cycle.
      p_next        = P_ACCEPT;
      acc_next      = '0;
      seen_next     = 1'b0;
      overflow_next = 1'b0;
      empty_next    = 1'b0;
      delim_next    = delimbyte;
    end else if (p_state == P_ACCEPT && byte_valid) begin
      if (shift == delim) begin
        result_next = acc;
        empty_next  = ~seen_digit;
        p_next      = P_READY;
      end else if (is_digit) begin
        seen_next = 1'b1;
        if (overflow || acc_x10 > 12'd255) begin
          acc_next      = 8'hFF;
          overflow_next = 1'b1;
        end else begin
          acc_next = acc_x10[7:0];
        end
      end
    end
  end

  assign result_ready = (p_state == P_READY) && !start;

endmodule

// File: tb/tb_indec_until_delim_1_1_8_8.sv
// Directed and randomized checks of the serial decimal decoder against a
// string-level model of the parse rules.
module tb_indec_until_delim_1_1_8_8;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       inchan = 1'b1;
  logic [7:0] delimbyte = 8'h00;
  logic [7:0] result;
  logic       result_ready;
  logic       overflow;
  logic       empty;

  int   checks = 0;
  int   errors = 0;
  logic pre_ready;

  indec_until_delim_1_1_8_8 #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .inchan       (inchan),
    .delimbyte    (delimbyte),
    .result       (result),
    .result_ready (result_ready),
    .overflow     (overflow),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame: start bit, 8 data bits LSB first, stop bit; each bit CPB clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (c == 0) inchan = f[i];
        if (i == 9 && c == CPB - 1) pre_ready = result_ready;
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    delimbyte = d;
    #1;
    check("ready_masked_by_start", result_ready, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("ready_low_while_busy", result_ready, 0);
  endtask

  function automatic void model(input string s, input logic [7:0] delim,
                                output int v, output bit ov, output bit emp);
    bit seen;
    seen = 0;
    v = 0;
    ov = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] ch;
      int dig;
      ch = s[i];
      if (ch == delim) break;
      if (ch >= 8'h30 && ch <= 8'h39) begin
        dig = int'(ch) - 48;
        seen = 1;
        if (ov || v * 10 + dig > 255) begin
          v = 255;
          ov = 1;
        end else begin
          v = v * 10 + dig;
        end
      end
    end
    emp = !seen;
  endfunction

  // Start a parse, stream the whole string back to back, then check the
  // outcome one clock after the final (delimiter) byte is received.
  task automatic run_case(input string tag, input logic [7:0] d, input string s);
    int v;
    bit ov, emp;
    model(s, d, v, ov, emp);
    pulse_start(d);
    send_str(s);
    check({tag, "_ready_before_delim"}, pre_ready, 0);
    @(negedge clk);
    check({tag, "_ready"}, result_ready, 1);
    check({tag, "_result"}, result, v);
    check({tag, "_overflow"}, overflow, ov);
    check({tag, "_empty"}, empty, emp);
  endtask

  initial begin
    int         v;
    bit         ov, emp;
    string      s;
    logic [7:0] d;
    logic [7:0] dl[3];
    logic [7:0] junk[4];
    dl = '{8'h2C, 8'h3B, 8'h0A};
    junk = '{8'h20, 8'h0D, 8'h2D, 8'h78};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_result", result, 0);
    check("reset_ready", result_ready, 1);
    check("reset_overflow", overflow, 0);
    check("reset_empty", empty, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_case("basic", 8'h2C, "123,");
    run_case("overflow", 8'h2C, "300,");
    run_case("after_overflow", 8'h2C, "25,");
    run_case("empty", 8'h2C, ",");
    run_case("zero", 8'h2C, "0,");
    run_case("cr_ignored", 8'h0A, "4\r2\n");
    run_case("digit_delim", 8'h35, "15");
    run_case("leading_zeros", 8'h2C, "007,");

    // Framing error: the '7' must be discarded.
    pulse_start(8'h2C);
    send_frame(8'h37, 1'b0);
    inchan = 1'b1;
    repeat (16) @(negedge clk);
    model("5,", 8'h2C, v, ov, emp);
    send_str("5,");
    @(negedge clk);
    check("framing_result", result, v);
    check("framing_ready", result_ready, 1);

    // Bytes arriving while idle are dropped.
    send_str("9");
    repeat (4) @(negedge clk);
    run_case("pre_start", 8'h2C, ",");

    // A two-clock low glitch must not start a frame.
    pulse_start(8'h2C);
    @(negedge clk);
    inchan = 1'b0;
    repeat (2) @(negedge clk);
    inchan = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_still_busy", result_ready, 0);
    model("6,", 8'h2C, v, ov, emp);
    send_str("6,");
    @(negedge clk);
    check("glitch_result", result, v);

    // Reset in the middle of a parse.
    pulse_start(8'h2C);
    send_str("12");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_result", result, 0);
    check("midreset_ready", result_ready, 1);
    check("midreset_overflow", overflow, 0);
    check("midreset_empty", empty, 0);
    repeat (4) @(negedge clk);
    run_case("after_reset", 8'h2C, "9,");

    // Restart mid-parse discards the partial value.
    pulse_start(8'h2C);
    send_str("88");
    run_case("restart", 8'h2C, "3,");

    // Randomized strings: digits with occasional ignored characters.
    for (int n = 0; n < 12; n++) begin
      int nd;
      d = dl[$urandom_range(0, 2)];
      nd = (n == 5) ? 0 : int'($urandom_range(1, 4));
      s = "";
      for (int k = 0; k < nd; k++) begin
        if ($urandom_range(0, 3) == 0)
          s = $sformatf("%s%c", s, junk[$urandom_range(0, 3)]);
        s = $sformatf("%s%c", s, 8'h30 + 8'($urandom_range(0, 9)));
      end
      s = $sformatf("%s%c", s, d);
      run_case($sformatf("rand%0d", n), d, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/indec_until_delim_1_1_8_8.md
# indec_until_delim_1_1_8_8

Serial-input decimal decoder; the receive-side counterpart of the decimal output routines in the simple I/O library. Samples a UART RX line (8N1, LSB first), parses ASCII decimal digits into an 8-bit unsigned value and finishes when a caller-supplied delimiter byte arrives. Uses the library's start / result / result_ready handshake, so generated loop FSMs call it like any other multi-cycle function.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200).
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  one-cycle pulse; begins a new parse, latches delimbyte.
- inchan  input  1  UART RX line, idle high, asynchronous to clk.
- delimbyte  input  8  terminating byte; sampled on the start cycle.
- result  output  8  parsed value; valid while result_ready is high.
- result_ready  output  1  high when idle/done and start is low (start masks it combinationally).
- overflow  output  1  value exceeded 255; result saturated.
- empty  output  1  delimiter arrived before any digit.

## Operation
- Reset (rst_n low at a clk edge): parser state READY, result=0, overflow=0, empty=0, accumulator=0, RX FSM IDLE, bit/clock counters=0, synchronizer flops=1. result_ready=1 after reset (unless start is high).
- inchan passes through a 2-flop synchronizer; all RX decisions use the second flop.
- RX FSM: IDLE -> START on synchronized low. START: count CLKS_PER_BIT/2 cycles; line still low -> DATA, else (glitch) -> IDLE. DATA: every CLKS_PER_BIT cycles sample one bit into shift register, LSB first, 8 bits. STOP: after CLKS_PER_BIT cycles sample; high -> one-cycle byte_valid strobe with the byte; low -> framing error, byte discarded, no strobe. Then IDLE (waits for line high before rearming).
- RX runs continuously regardless of parser state; byte_valid strobes while parser is READY are dropped.
- Parser FSM: READY --start--> ACCEPT; ACCEPT --byte_valid & byte==delim--> READY.
- On start (any state): acc=0, seen_digit=0, overflow=0, empty=0, delim latched, -> ACCEPT. Restart mid-parse discards partial value.
- In ACCEPT, per byte_valid, priority order:
  - byte == delim: result<=acc, empty<=~seen_digit, -> READY. Delimiter check wins even if delim is a digit.
  - byte in 0x30..0x39: d=byte-0x30; t=acc*10+d computed in 12 bits; if overflow already set or t>255 -> acc=255, overflow=1; else acc=t[7:0]. seen_digit=1.
  - any other byte (CR, space, sign): ignored, no state change.
- result/overflow/empty hold their values in READY until the next start clears overflow/empty; result holds its last value until the next delimiter.
- Leading zeros accepted ("007" -> 7).

## Timing
- Byte latency: byte_valid fires at the stop-bit mid-sample, ~9.5*CLKS_PER_BIT + 2 (synchronizer) cycles after the start-bit falling edge.
- Delimiter byte_valid at cycle T -> result, overflow, empty registered at T+1; result_ready high from T+1.
- start at cycle S: result_ready low in S (combinational mask) and from S+1 until delimiter completion.
- start coinciding with byte_valid: start wins; the byte is dropped.
- rst_n low overrides start and byte_valid in the same cycle.
- Back-to-back frames (stop bit immediately followed by next start bit) must be received without loss.

## Test plan
Bench uses CLKS_PER_BIT=8, driver produces ideal 8N1 frames.
- start with delim 0x2C, send "123," -> result=123, overflow=0, empty=0; result_ready rises exactly 1 cycle after the ',' byte_valid.
- start, send "300," -> result=255, overflow=1; then start, "25," -> result=25, overflow=0.
- start, send "," alone -> result=0, empty=1; send "0," after a new start -> result=0, empty=0.
- delim 0x0A: send "4\r2\n" -> result=42 (CR ignored); delim 0x35 ('5'): send "15" -> result=1.
- Send '7' with stop bit forced low, then "5," -> result=5; a 2-cycle low glitch on inchan produces no byte; bytes sent before start ("9") are dropped.
- Mid-parse ("12" sent) pulse rst_n low 1 cycle -> result=0, result_ready=1, overflow=0; then start, "9," -> result=9; also start pulse mid-parse after "88" then "3," -> result=3.
